systola_feeder: RTL and testbench
=================================

# systola_feeder

Input sequencer for the PE_ARR systolic array. Accepts an activation matrix A (ROWS×K) and a weight matrix W (K×COLS) as a byte stream, stores them, and on `start` drives the array's per-row activation lanes and per-column weight lanes. Each lane is skewed by its index so operands meet diagonally. It also generates the array's `fire` strobe and signals completion after the partial sums have drained.

## Interface
- ROWS, 4, array rows; number of activation lanes
- COLS, 4, array columns; number of weight lanes
- K, 4, reduction depth (shared inner dimension)
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- ld_valid  in  1  load byte valid
- ld_ready  out  1  feeder can accept a load byte
- ld_data  in  8  load byte
- start  in  1  begin a feed run (single-cycle pulse)
- busy  out  1  high in FEED and DRAIN
- done  out  1  one-cycle pulse when a run completes
- fire  out  1  to array `fire`; high for every FEED cycle
- out_a  out  8×ROWS  unpacked array [0:ROWS-1], to array activation inputs
- out_w  out  8×COLS  unpacked array [0:COLS-1], to array weight inputs

## Operation
- States: LOAD, ARMED, FEED, DRAIN.
- Reset state is LOAD. The load counter, feed counter and drain counter are cleared. `ld_ready`=1; `busy`, `done`, `fire`=0; all `out_a` and `out_w` lanes are 0.
- **LOAD:** each byte transfers when `ld_valid && ld_ready`.
  - Order: A row-major (A[0][0], A[0][1], …), then W column-major (W[0][0], W[1][0], …).
  - Total L = ROWS·K + K·COLS bytes.
  - Transfer number L moves the block to ARMED.
  - `start` is ignored in LOAD.
- **ARMED:** `ld_ready`=0. On `start`, move to FEED with t=0.
- **FEED:** lasts F = K + max(ROWS,COLS) − 1 cycles, t = 0…F−1.
  - out_a[i] = A[i][t−i] when 0 ≤ t−i < K, else 0.
  - out_w[j] = W[t−j][j] when 0 ≤ t−j < K, else 0.
  - `fire`=1 for the whole state.
  - After cycle F−1, move to DRAIN.
- **DRAIN:** lasts ROWS+COLS cycles. `fire`=0 and all lanes are 0.
  - After the last DRAIN cycle: `done`=1 for one cycle, the state returns to LOAD, and the load counter is 0.
- `start` while busy is ignored. `ld_valid` outside LOAD is ignored; no byte is consumed.
- A `start` and the final load transfer in the same cycle: the start is ignored. The block only enters ARMED.
- `rstn` low mid-run aborts the run asynchronously to the reset state. Stored matrix contents are don't-care. No `done` is produced.
- No arithmetic on data. Accumulation width (12 bits in the array) is the array's concern.

## Timing
- `start` sampled in cycle n gives FEED cycle t=0 in cycle n+1. The t=0 lane values and `fire`=1 are registered outputs visible in n+1.
- `done` is asserted in cycle n + F + ROWS + COLS + 1.
- `busy` = 1 from cycle n+1 through the last DRAIN cycle.
- `ld_ready` is 0 from the cycle after the final transfer until the cycle `done` is asserted, inclusive. It is 1 again the cycle after `done`.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `SYSTOLA_FEED_REUSE_W_EN` undefined: every run requires a full load of L bytes.
- Defined: after the first completed run, W is retained.
  - Subsequent loads accept only ROWS·K bytes (A only); the last one moves the block to ARMED.
  - Reset restores the full-load requirement.

## Structure
- Package `systola_pkg` holds:
  - DATA_W=8 and ACC_W=12
  - the feeder state enum `feed_state_t`
  - the function `skew_len(rows, cols, k)` returning F
- One sub-module `systola_skew_line`: a parameterised DELAY-stage 8-bit register delay line with zero reset.
  - One instance per lane, with DELAY = lane index.
  - Each lane is fed an unskewed stream A[i][t] or W[t][j], with 0 for t ≥ K.
  - `fire` is aligned to the t=0 input of the skew lines.

## Test plan
- **Basic 2×2×2:** ROWS=COLS=K=2, A={{1,2},{3,4}}, W={{5,6},{7,8}}, then start → FEED 3 cycles.
  - out_a[0]=1,2,0 and out_a[1]=0,3,4.
  - out_w[0]=5,7,0 and out_w[1]=0,6,8.
  - `fire`=1,1,1; `done` asserted 8 cycles after start.
- **Premature start:** start after 3 of 8 bytes → ignored. `busy` stays 0, `ld_ready` stays 1, and the remaining 5 bytes are still accepted.
- **Load backpressure:** `ld_valid` held high through ARMED/FEED → no extra bytes consumed. The next load begins only after `done`.
- **Reset mid-FEED:** drop `rstn` at t=1 → all lanes 0, `fire`=0 and `ld_ready`=1 immediately. `done` is never asserted.
- **End-to-end with PE_ARR:** 4×4 identity A with W = 1…16 → array results equal W after `done`.
- **Reuse (macro defined):** after a first run, load 4 A bytes only → ARMED. A second run reuses the previous W values.

Source files
------------

// File: rtl/systola_pkg.sv
// systola_pkg: shared definitions for the PE_ARR input feeder.
//   DATA_W       operand byte width
//   ACC_W        accumulator width inside the array (informational here)
//   feed_state_t feeder control states
//   skew_len()   number of FEED cycles for a given array geometry
package systola_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 12;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FEED  = 2'd2,
    ST_DRAIN = 2'd3
  } feed_state_t;

  // Last operand of the longest lane leaves at t = K-1 + max(rows, cols)-1.
  function automatic int skew_len(input int rows, input int cols, input int k);
    return k + ((rows > cols) ? rows : cols) - 1;
  endfunction

endpackage

// File: rtl/systola_skew_line.sv
// systola_skew_line: DELAY-stage byte delay line used to skew one array lane.
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset, clears every stage to zero
//   din   unskewed lane operand
//   dout  operand delayed by DELAY cycles (DELAY = 0 is a straight wire)
module systola_skew_line
  import systola_pkg::*;
#(
  parameter int DELAY = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  generate
    if (DELAY == 0) begin : g_wire
      // Lane 0 needs no skew; clock and reset are intentionally unused.
      logic unused_ctl;
      assign unused_ctl = clk ^ rstn;
      assign dout       = din;
    end else begin : g_reg
      logic [DATA_W-1:0] tap_p [DELAY];

      // stage boundary: one register per unit of skew
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int s = 0; s < DELAY; s++) tap_p[s] <= '0;
        end else begin
          tap_p[0] <= din;
          for (int s = 1; s < DELAY; s++) tap_p[s] <= tap_p[s-1];
        end
      end

      assign dout = tap_p[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/systola_feeder.sv
// systola_feeder: loads A (ROWS x K) and W (K x COLS) from a byte stream and,
// on start, drives skewed activation/weight lanes plus the fire strobe into
// the PE_ARR systolic array, then waits for the array to drain.
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   ld_valid  load byte valid         ld_ready  feeder accepts a byte
//   ld_data   load byte (A row-major, then W column-major)
//   start     begin a run (honoured only when armed)
//   busy      high during FEED and DRAIN
//   done      one-cycle pulse after DRAIN
//   fire      array fire strobe, high for every FEED cycle
//   out_a     per-row activation lanes, lane i delayed by i
//   out_w     per-column weight lanes, lane j delayed by j
// Build option: define SYSTOLA_FEED_REUSE_W_EN to keep W after the first
// completed run, so later loads carry only the ROWS*K activation bytes.
module systola_feeder
  import systola_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fire,
  output logic [DATA_W-1:0] out_a [0:ROWS-1],
  output logic [DATA_W-1:0] out_w [0:COLS-1]
);

  localparam int RK   = ROWS * K;
  localparam int KC   = K * COLS;
  localparam int L    = RK + KC;
  localparam int F    = skew_len(ROWS, COLS, K);
  localparam int D    = ROWS + COLS;
  localparam int TMAX = (F > D) ? F : D;
  localparam int LCW  = $clog2(L + 1);
  localparam int TCW  = $clog2(TMAX + 1);
  localparam int AIW  = (RK > 1) ? $clog2(RK) : 1;
  localparam int WIW  = (KC > 1) ? $clog2(KC) : 1;

  feed_state_t       state_q, state_d;
  logic [LCW-1:0]    ld_cnt_q, ld_cnt_d;
  logic [TCW-1:0]    t_q, t_d;
  logic              ld_ready_q, ld_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              vld_p0, vld_d;
  logic              ld_xfer;
  logic [LCW-1:0]    ld_last;
  logic              tap_vld;
  logic [TCW-1:0]    tap_idx;
  logic [AIW-1:0]    a_wr_idx;
  logic [WIW-1:0]    w_wr_idx;

  logic [DATA_W-1:0] a_mem [RK];
  logic [DATA_W-1:0] w_mem [KC];
  logic [DATA_W-1:0] stream_a_p0 [ROWS];
  logic [DATA_W-1:0] stream_a_d  [ROWS];
  logic [DATA_W-1:0] stream_w_p0 [COLS];
  logic [DATA_W-1:0] stream_w_d  [COLS];

`ifdef SYSTOLA_FEED_REUSE_W_EN
  logic w_kept_q, w_kept_d;
  assign ld_last = w_kept_q ? LCW'(RK - 1) : LCW'(L - 1);
`else
  assign ld_last = LCW'(L - 1);
`endif

  assign ld_xfer  = (state_q == ST_LOAD) && ld_ready_q && ld_valid;
  assign a_wr_idx = AIW'(ld_cnt_q);
  assign w_wr_idx = WIW'(ld_cnt_q - LCW'(RK));

  // Next-state and next-output logic. tap_idx selects which unskewed column
  // of A / row of W enters the skew lines on the next cycle.
  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    t_d        = t_q;
    ld_ready_d = ld_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    vld_d      = 1'b0;
    tap_vld    = 1'b0;
    tap_idx    = '0;
`ifdef SYSTOLA_FEED_REUSE_W_EN
    w_kept_d   = w_kept_q;
`endif

    case (state_q)
      ST_LOAD: begin
        // ld_ready stays low through the done cycle and rises right after.
        if (done_q) ld_ready_d = 1'b1;
        if (ld_xfer) begin
          if (ld_cnt_q == ld_last) begin
            state_d    = ST_ARMED;
            ld_cnt_d   = '0;
            ld_ready_d = 1'b0;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (start) begin
          state_d = ST_FEED;
          t_d     = '0;
          busy_d  = 1'b1;
          vld_d   = 1'b1;
          tap_vld = 1'b1;
          tap_idx = '0;
        end
      end
      ST_FEED: begin
        if (t_q == TCW'(F - 1)) begin
          state_d = ST_DRAIN;
          t_d     = '0;
        end else begin
          t_d     = t_q + 1'b1;
          vld_d   = 1'b1;
          tap_idx = t_q + 1'b1;
          tap_vld = (int'(t_q) + 1 < K);
        end
      end
      ST_DRAIN: begin
        if (t_q == TCW'(D - 1)) begin
          state_d  = ST_LOAD;
          t_d      = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          ld_cnt_d = '0;
`ifdef SYSTOLA_FEED_REUSE_W_EN
          w_kept_d = 1'b1;
`endif
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    for (int i = 0; i < ROWS; i++)
      stream_a_d[i] = tap_vld ? a_mem[AIW'(i * K + int'(tap_idx))] : '0;
    for (int j = 0; j < COLS; j++)
      stream_w_d[j] = tap_vld ? w_mem[WIW'(j * K + int'(tap_idx))] : '0;
  end

  // stage boundary p0: control state plus the unskewed lane operands,
  // with fire (vld_p0) aligned to the t=0 operands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_LOAD;
      ld_cnt_q   <= '0;
      t_q        <= '0;
      ld_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_p0     <= 1'b0;
`ifdef SYSTOLA_FEED_REUSE_W_EN
      w_kept_q   <= 1'b0;
`endif
      for (int i = 0; i < ROWS; i++) stream_a_p0[i] <= '0;
      for (int j = 0; j < COLS; j++) stream_w_p0[j] <= '0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      t_q        <= t_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vld_p0     <= vld_d;
`ifdef SYSTOLA_FEED_REUSE_W_EN
      w_kept_q   <= w_kept_d;
`endif
      for (int i = 0; i < ROWS; i++) stream_a_p0[i] <= stream_a_d[i];
      for (int j = 0; j < COLS; j++) stream_w_p0[j] <= stream_w_d[j];
    end
  end

  // Operand storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (ld_xfer) begin
      if (int'(ld_cnt_q) < RK) a_mem[a_wr_idx] <= ld_data;
      else                     w_mem[w_wr_idx] <= ld_data;
    end
  end

  // stage boundary: per-lane skew, lane index = delay
  for (genvar i = 0; i < ROWS; i++) begin : g_a
    systola_skew_line #(.DELAY(i)) u_line (
      .clk  (clk),
      .rstn (rstn),
      .din  (stream_a_p0[i]),
      .dout (out_a[i])
    );
  end

  for (genvar j = 0; j < COLS; j++) begin : g_w
    systola_skew_line #(.DELAY(j)) u_line (
      .clk  (clk),
      .rstn (rstn),
      .din  (stream_w_p0[j]),
      .dout (out_w[j])
    );
  end

  assign ld_ready = ld_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fire     = vld_p0;

endmodule

// File: tb/tb_systola_feeder.sv
// tb_systola_feeder: directed bench for systola_feeder on a 2x2x2 geometry,
// with a cycle-level reference model of the feeder's observable behaviour.
module tb_systola_feeder;

  localparam int R  = 2;
  localparam int C  = 2;
  localparam int KK = 2;
  localparam int RK = R * KK;
  localparam int L  = RK + KK * C;
  localparam int F  = KK + ((R > C) ? R : C) - 1;
  localparam int D  = R + C;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       ld_valid = 1'b0;
  logic       ld_ready;
  logic [7:0] ld_data = 8'h00;
  logic       start = 1'b0;
  logic       busy, done, fire;
  logic [7:0] out_a [0:R-1];
  logic [7:0] out_w [0:C-1];

  int errors = 0;
  int checks = 0;

  systola_feeder #(.ROWS(R), .COLS(C), .K(KK)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .fire     (fire),
    .out_a    (out_a),
    .out_w    (out_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. s = cycles since the accepted start (0 = first FEED
  // cycle, F+D = done cycle), -1 when no run is active. got = bytes stored.
  logic [7:0] mem [L];
  int s   = -1;
  int got = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s   = -1;
      got = 0;
    end else if (s >= 0) begin
      if (s == F + D) begin
        s   = -1;
        got = 0;
      end else begin
        s++;
      end
    end else if (got < L && ld_valid) begin
      mem[got] = ld_data;
      got++;
    end else if (got == L && start) begin
      s = 0;
    end
  end

  function automatic logic [7:0] exp_a(input int i);
    int k = s - i;
    if (s >= 0 && s < F && k >= 0 && k < KK) return mem[i * KK + k];
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_w(input int j);
    int k = s - j;
    if (s >= 0 && s < F && k >= 0 && k < KK) return mem[RK + j * KK + k];
    return 8'h00;
  endfunction

  always @(negedge clk) begin
    check("m_ld_ready", ld_ready, (s < 0 && got < L));
    check("m_busy", busy, (s >= 0 && s < F + D));
    check("m_done", done, (s == F + D));
    check("m_fire", fire, (s >= 0 && s < F));
    for (int i = 0; i < R; i++) check($sformatf("m_out_a%0d", i), out_a[i], exp_a(i));
    for (int j = 0; j < C; j++) check($sformatf("m_out_w%0d", j), out_w[j], exp_w(j));
  end

  // All stimulus tasks start and end at posedge + 2.
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    ld_valid = 1'b1;
    ld_data  = b;
    while (!ld_ready && n < 50) begin step(1); n++; end
    if (!ld_ready) check("push_timeout", 0, 1);
    step(1);
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic load8(input logic [7:0] base);
    for (int b = 0; b < L; b++) push(base + 8'(b));
  endtask

  task automatic run_to_done;
    int n = 0;
    pulse_start();
    while (!done && n < 40) begin step(1); n++; end
    check("run_done", done, 1);
    step(1);
  endtask

  logic [7:0] bytes1 [L] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd6, 8'd8};
  logic [7:0] ea0 [F] = '{8'd1, 8'd2, 8'd0};
  logic [7:0] ea1 [F] = '{8'd0, 8'd3, 8'd4};
  logic [7:0] ew0 [F] = '{8'd5, 8'd7, 8'd0};
  logic [7:0] ew1 [F] = '{8'd0, 8'd6, 8'd8};

  initial begin
    #1 rstn = 1'b0;
    @(posedge clk); #2;
    check("rst_ld_ready", ld_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fire", fire, 0);
    check("rst_out_a0", out_a[0], 0);
    step(1);
    rstn = 1'b1;
    step(1);

    // Basic 2x2x2 run with literal lane values.
    for (int b = 0; b < L; b++) push(bytes1[b]);
    check("armed_ld_ready", ld_ready, 0);
    pulse_start();
    for (int t = 0; t < F; t++) begin
      check($sformatf("lit_a0_t%0d", t), out_a[0], ea0[t]);
      check($sformatf("lit_a1_t%0d", t), out_a[1], ea1[t]);
      check($sformatf("lit_w0_t%0d", t), out_w[0], ew0[t]);
      check($sformatf("lit_w1_t%0d", t), out_w[1], ew1[t]);
      check($sformatf("lit_fire_t%0d", t), fire, 1);
      check($sformatf("lit_busy_t%0d", t), busy, 1);
      step(1);
    end
    step(3);
    check("lit_done_n7", done, 0);
    step(1);
    check("lit_done_n8", done, 1);
    check("lit_ready_done", ld_ready, 0);
    step(1);
    check("lit_done_n9", done, 0);
    check("lit_ready_after", ld_ready, 1);
    check("lit_busy_after", busy, 0);

    // Premature start after 3 bytes is ignored.
    for (int b = 0; b < 3; b++) push(8'h10 + 8'(b));
    pulse_start();
    check("pre_busy", busy, 0);
    check("pre_ready", ld_ready, 1);
    for (int b = 3; b < L; b++) push(8'h10 + 8'(b));
    check("pre_armed", ld_ready, 0);
    step(1);
    run_to_done();

    // Start coinciding with the final transfer is ignored.
    for (int b = 0; b < L - 1; b++) push(8'h30 + 8'(b));
    start = 1'b1;
    push(8'h3F);
    start = 1'b0;
    check("coinc_busy", busy, 0);
    check("coinc_armed", ld_ready, 0);
    step(2);
    run_to_done();

    // Backpressure: ld_valid held high through ARMED/FEED/DRAIN.
    load8(8'h50);
    ld_valid = 1'b1;
    ld_data  = 8'hEE;
    pulse_start();
    begin
      int n = 0;
      while (!done && n < 40) begin step(1); n++; end
      check("bp_done", done, 1);
      check("bp_ready_done", ld_ready, 0);
    end
    step(1);
    check("bp_ready_after", ld_ready, 1);
    ld_valid = 1'b0;
    step(1);

    // Reset at FEED t=1.
    load8(8'h21);
    pulse_start();
    step(1);
    check("rm_a0_t1", out_a[0], 8'h22);
    check("rm_a1_t1", out_a[1], 8'h23);
    #1 rstn = 1'b0;
    #1;
    check("rm_a0", out_a[0], 0);
    check("rm_a1", out_a[1], 0);
    check("rm_w0", out_w[0], 0);
    check("rm_w1", out_w[1], 0);
    check("rm_fire", fire, 0);
    check("rm_ready", ld_ready, 1);
    check("rm_busy", busy, 0);
    @(posedge clk); #2;
    rstn = 1'b1;
    step(12);

    // Full run after reset with fresh data.
    load8(8'hA1);
    step(1);
    run_to_done();
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang, expected finish");
    $fatal(1);
  end

endmodule
